wb_spi_master: RTL and testbench

- Wishbone-slave SPI master: CPU writes a control register and a TX byte over a 32-bit classic Wishbone bus; the block shifts the byte out on MOSI while shifting a byte in from MISO.
- On completion it sets an interrupt-pending flag, optionally driving irq.
- Sits between the system bus and an external SPI peripheral, e.g. a 25xx-series serial EEPROM (SPI mode 0).

---
 rtl/wb_spi_master.sv | 141 ++++++++++++++
 tb/tb_wb_spi_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_spi_master.sv
`timescale 1ns/1ps
// wb_spi_master: classic Wishbone slave with a DATA and a CTRL register that
// runs single-byte SPI mode-0 transfers. Define SPI_LSB_FIRST_EN for LSB-first shifting.
module wb_spi_master #(
  parameter logic [7:0]  DIV_RESET = 8'hFF,
  parameter logic [31:0] ADDR_DATA = 32'h0000_0010,
  parameter logic [31:0] ADDR_CTRL = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_addr,
  input  logic        wb_we,
  input  logic        wb_stb,
  input  logic        wb_cyc,
  input  logic [31:0] wb_dout,
  output logic [31:0] wb_din,
  output logic        wb_ack,
  output logic        spi_mosi,
  output logic        spi_sck,
  output logic        spi_ss,
  input  logic        spi_miso,
  output logic        irq
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state_q;
  logic       ack_q, busy_q, flag_q, int_en_q, ss_act_q, en_q, sck_q, mosi_q;
  logic [7:0] div_q, cnt_q, tx_q, rxsh_q, rx_q;
  logic [3:0] half_q;

  logic       bus_req, wr_data, wr_ctrl;
  logic       tx_first, tx_next_bit;
  logic [7:0] tx_shifted, rx_shifted;
  logic       unused_ok;

  assign bus_req   = wb_cyc & wb_stb & ~ack_q;
  assign wr_data   = bus_req & wb_we & (wb_addr == ADDR_DATA);
  assign wr_ctrl   = bus_req & wb_we & (wb_addr == ADDR_CTRL);
  assign unused_ok = ^{wb_dout[31:13], wb_dout[9]};

  // Bit order is the only thing the build option changes.
  always_comb begin
`ifdef SPI_LSB_FIRST_EN
    tx_first    = wb_dout[0];
    tx_shifted  = {1'b0, tx_q[7:1]};
    tx_next_bit = tx_q[1];
    rx_shifted  = {spi_miso, rxsh_q[7:1]};
`else
    tx_first    = wb_dout[7];
    tx_shifted  = {tx_q[6:0], 1'b0};
    tx_next_bit = tx_q[6];
    rx_shifted  = {rxsh_q[6:0], spi_miso};
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      flag_q   <= 1'b0;
      int_en_q <= 1'b0;
      ss_act_q <= 1'b0;
      en_q     <= 1'b0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      div_q    <= DIV_RESET;
      cnt_q    <= '0;
      tx_q     <= '0;
      rxsh_q   <= '0;
      rx_q     <= '0;
      half_q   <= '0;
    end else begin
      ack_q <= bus_req;
      if (wr_ctrl) begin
        div_q    <= wb_dout[7:0];
        int_en_q <= wb_dout[10];
        ss_act_q <= wb_dout[11];
        en_q     <= wb_dout[12];
        if (wb_dout[8]) flag_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (wr_data && en_q) begin
            tx_q    <= wb_dout[7:0];
            mosi_q  <= tx_first;
            flag_q  <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= div_q;
            half_q  <= '0;
            sck_q   <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (wr_ctrl && !wb_dout[12]) begin
            sck_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == '0) begin
            cnt_q  <= div_q;
            sck_q  <= ~sck_q;
            half_q <= half_q + 4'd1;
            if (!sck_q) begin
              rxsh_q <= rx_shifted;
            end else begin
              tx_q   <= tx_shifted;
              mosi_q <= tx_next_bit;
              // Assigned after INT_CLR above so completion wins a same-edge clear.
              if (half_q == 4'd15) begin
                rx_q    <= rxsh_q;
                busy_q  <= 1'b0;
                flag_q  <= 1'b1;
                state_q <= IDLE;
              end
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    wb_din = '0;
    if (wb_addr == ADDR_DATA)
      wb_din = {22'b0, flag_q, busy_q, rx_q};
    else if (wb_addr == ADDR_CTRL)
      wb_din = {19'b0, en_q, ss_act_q, int_en_q, flag_q, 1'b0, div_q};
  end

  assign wb_ack   = ack_q;
  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;
  assign spi_ss   = ~ss_act_q;
  assign irq      = flag_q & int_en_q;

endmodule

// File: tb/tb_wb_spi_master.sv
`timescale 1ns/1ps
// tb_wb_spi_master: randomized bus transfers against an SPI slave model and
// a transaction-level reference (expected RX = slave byte, latency = 16*(DIV+1)).
module tb_wb_spi_master;

  localparam logic [31:0] A_DATA = 32'h0000_0010;
  localparam logic [31:0] A_CTRL = 32'h0000_0020;
  localparam int unsigned TCLK   = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_addr, wb_dout, wb_din;
  logic        wb_we, wb_stb, wb_cyc, wb_ack;
  logic        spi_mosi, spi_sck, spi_ss, spi_miso, irq;

  always #5 clk = ~clk;

  wb_spi_master #(
    .DIV_RESET(8'hFF),
    .ADDR_DATA(A_DATA),
    .ADDR_CTRL(A_CTRL)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_addr(wb_addr), .wb_we(wb_we), .wb_stb(wb_stb), .wb_cyc(wb_cyc),
    .wb_dout(wb_dout), .wb_din(wb_din), .wb_ack(wb_ack),
    .spi_mosi(spi_mosi), .spi_sck(spi_sck), .spi_ss(spi_ss),
    .spi_miso(spi_miso), .irq(irq)
  );

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc_cnt = 0;
  int unsigned ack_cyc = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // SCK monitor: MOSI as seen on each rising edge, with its timestamp.
  logic            mosi_log[$];
  longint unsigned rise_t[$];
  int unsigned     nfall = 0;
  always @(posedge spi_sck) begin
    mosi_log.push_back(spi_mosi);
    rise_t.push_back($time);
  end
  always @(negedge spi_sck) nfall++;

  // Mode-0 slave: first bit valid before the first rising edge, next bit after each falling edge.
  logic [7:0]  slave_byte = '0;
  int unsigned fall_base = 0;

  function automatic logic slave_bit(input logic [7:0] b, input int unsigned i);
    if (i > 7) return 1'b0;
`ifdef SPI_LSB_FIRST_EN
    return b[3'(i)];
`else
    return b[3'(7 - i)];
`endif
  endfunction

  assign spi_miso = slave_bit(slave_byte, nfall - fall_base);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    bit got;
    @(negedge clk);
    wb_addr = a; wb_dout = d; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (wb_ack) got = 1'b1;
    end
    check("wr_ack", got, 1);
    ack_cyc = cyc_cnt;
    wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    bit got;
    @(negedge clk);
    wb_addr = a; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    got = 1'b0;
    d = '0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (wb_ack) begin
        got = 1'b1;
        d = wb_din;
      end
    end
    check("rd_ack", got, 1);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    check("ack_pulse", wb_ack, 0);
  endtask

  task automatic wait_flag(input int unsigned t0, input int unsigned limit,
                           output int unsigned lat, output bit ok);
    ok = 1'b0;
    lat = 0;
    wb_addr = A_DATA;
    for (int unsigned i = 0; i < limit && !ok; i++) begin
      @(posedge clk); #1;
      if (wb_din[9]) begin
        ok = 1'b1;
        lat = cyc_cnt - t0;
      end
    end
  endtask

  task automatic run_xfer(input logic [7:0] div, input logic [7:0] tx, input logic [7:0] sb,
                          input logic inten, input bit poke);
    int unsigned t0, lat, rbase, dv;
    bit          ok;
    logic [31:0] rd;
    logic [7:0]  seen;
    dv = div;
    slave_byte = sb;
    fall_base = nfall;
    rbase = mosi_log.size();
    wb_write(A_DATA, {24'h0, tx});
    t0 = ack_cyc;
    wb_read(A_DATA, rd);
    check("busy_set", rd[9:8], 2'b01);
    if (poke) wb_write(A_DATA, {24'h0, ~tx});
    wait_flag(t0, 16 * (dv + 1) + 64, lat, ok);
    check("done", ok, 1);
    check("latency", lat, 16 * (dv + 1));
    check("irq", irq, inten);
    check("sck_rises", mosi_log.size() - rbase, 8);
    if (mosi_log.size() - rbase >= 8) begin
      seen = '0;
      for (int unsigned i = 0; i < 8; i++) begin
`ifdef SPI_LSB_FIRST_EN
        seen = {mosi_log[rbase + i], seen[7:1]};
`else
        seen = {seen[6:0], mosi_log[rbase + i]};
`endif
      end
      check("mosi_byte", seen, tx);
      check("sck_period", 32'((rise_t[rbase + 7] - rise_t[rbase]) / (7 * TCLK)), 2 * (dv + 1));
    end
    check("sck_idle", spi_sck, 0);
    wb_read(A_DATA, rd);
    check("data_rd", rd, {22'b0, 2'b10, sb});
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  last_rx, div, tx, sb;
    logic        inten;

    rst = 1'b0;
    wb_addr = A_CTRL; wb_dout = '0; wb_we = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0;
    #200;
    check("rst_ss", spi_ss, 1);
    check("rst_sck", spi_sck, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_irq", irq, 0);
    check("rst_ack", wb_ack, 0);
    check("rst_din_ctrl", wb_din, 32'h0000_00FF);
    @(negedge clk) rst = 1'b1;

    wb_read(A_CTRL, rd);
    check("ctrl_reset", rd, 32'h0000_00FF);
    wb_read(A_DATA, rd);
    check("data_reset", rd, 32'h0);

    wb_write(A_CTRL, 32'hFFFF_FEFF);
    check("ss_active", spi_ss, 0);
    wb_read(A_CTRL, rd);
    check("ctrl_rd", rd, 32'h0000_1CFF);
    run_xfer(8'hFF, 8'h0B, 8'hA5, 1'b1, 1'b0);
    wb_read(A_CTRL, rd);
    check("ctrl_flag", rd, 32'h0000_1EFF);

    wb_write(A_CTRL, 32'hFFFF_FFFF);
    check("irq_clr", irq, 0);
    wb_read(A_CTRL, rd);
    check("ctrl_clr", rd, 32'h0000_1CFF);

    wb_write(A_CTRL, 32'hFFFF_F6FF);
    check("ss_release", spi_ss, 1);
    run_xfer(8'hFF, 8'h0A, 8'h3C, 1'b1, 1'b1);

    wb_write(32'h0000_0030, 32'hFFFF_FFFF);
    wb_write(32'h8000_0020, 32'h0);
    wb_read(A_CTRL, rd);
    check("unmapped_wr", rd, 32'h0000_16FF);
    wb_read(32'h0000_0030, rd);
    check("unmapped_rd", rd, 32'h0);

    last_rx = 8'h3C;
    for (int unsigned n = 0; n < 12; n++) begin
      div   = 8'($urandom_range(0, 3));
      tx    = 8'($urandom);
      sb    = 8'($urandom);
      inten = 1'($urandom_range(0, 1));
      wb_write(A_CTRL, {19'b0, 1'b1, 1'b1, inten, 1'b1, 1'b1, div});
      wb_read(A_CTRL, rd);
      check("ctrl_rand", rd, {19'b0, 1'b1, 1'b1, inten, 1'b0, 1'b0, div});
      run_xfer(div, tx, sb, inten, 1'b0);
      last_rx = sb;
    end

    wb_write(A_CTRL, {19'b0, 3'b110, 2'b01, 8'h00});
    slave_byte = 8'($urandom);
    fall_base = nfall;
    wb_write(A_DATA, 32'($urandom_range(0, 255)));
    wb_write(A_CTRL, 32'h0000_0800);
    check("abort_sck", spi_sck, 0);
    wb_read(A_DATA, rd);
    check("abort_data", rd, {22'b0, 2'b00, last_rx});
    repeat (40) @(posedge clk);
    #1;
    check("abort_sck_hold", spi_sck, 0);
    check("abort_irq", irq, 0);
    wb_write(A_DATA, 32'h0000_0077);
    wb_read(A_DATA, rd);
    check("en0_ignored", rd, {22'b0, 2'b00, last_rx});
    wb_read(A_CTRL, rd);
    check("ctrl_final", rd, 32'h0000_0800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
